mw_stage_ctrl: RTL and testbench

// - Memory/writeback (MW) pipeline stage of the 3-stage core; sits after execute, ahead of the register file.
// - Captures the EX result, runs the data-memory request/response handshake and produces the regfile write.
// - Drives MW-slot status to the hazard unit; consumes its stall.
// - Also produces mem_busy, which freezes fetch/execute while a memory access is outstanding.

---
 rtl/mw_stage_ctrl_pkg.sv | 19 +
 rtl/mw_stage_ctrl_if.sv | 24 ++
 rtl/mw_stage_ctrl_dmem_access_fsm.sv | 62 ++++++
 rtl/mw_stage_ctrl.sv | 105 ++++++++++
 tb/tb_mw_stage_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mw_stage_ctrl_pkg.sv
// Shared types and constants for the memory/writeback stage.
package mw_stage_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  // Writeback source select carried with each instruction.
  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_PC4 = 2'b01,
    WB_MEM = 2'b10
  } wb_sel_e;

  // Data-memory access state, kept as plain constants for legacy tooling.
  typedef logic [1:0] mem_state_e;
  localparam mem_state_e ST_IDLE = 2'd0;
  localparam mem_state_e ST_REQ  = 2'd1;
  localparam mem_state_e ST_WAIT = 2'd2;

endpackage

// File: rtl/mw_stage_ctrl_if.sv
// Data-memory request/response bus between the MW stage and memory.
interface mw_stage_ctrl_if #(
  parameter int unsigned XLEN = 32
);

  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/mw_stage_ctrl_dmem_access_fsm.sv
// Data-memory access sequencer: request, optional response wait, and the
// mem_busy hold that freezes the front of the pipe while an access is open.
module dmem_access_fsm
  import mw_stage_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   slot_load,
  input  logic                   slot_store,
  input  logic [XLEN-1:0]        slot_addr,
  input  logic [XLEN-1:0]        slot_wdata,
  mw_stage_ctrl_if.master        dmem,
  output logic                   mem_busy
);

  mem_state_e state;
  mem_state_e state_next;

  // Loads stay busy for the whole request phase so the retire cycle is at
  // least the cycle after the grant; a store frees the pipe on its grant.
  always_comb begin
    mem_busy = 1'b0;
    unique case (state)
      ST_REQ:  mem_busy = slot_load | ~(dmem.gnt & slot_store);
      ST_WAIT: mem_busy = ~dmem.rvalid;
      default: mem_busy = 1'b0;
    endcase
  end

  // Whenever the pipe is not held, the slot reloads on this edge, so the
  // next state is decided by whether a new access is being captured.
  always_comb begin
    state_next = state;
    if (!mem_busy) begin
      state_next = start ? ST_REQ : ST_IDLE;
    end else begin
      unique case (state)
        ST_REQ:  state_next = (dmem.gnt && slot_load) ? ST_WAIT : ST_REQ;
        ST_WAIT: state_next = ST_WAIT;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign dmem.req   = (state == ST_REQ);
  assign dmem.we    = (state == ST_REQ) & slot_store;
  assign dmem.addr  = slot_addr;
  assign dmem.wdata = slot_wdata;

endmodule

// File: rtl/mw_stage_ctrl.sv
// Memory/writeback stage: MW pipeline register, hazard-unit status and the
// register-file write port; memory sequencing lives in dmem_access_fsm.
module mw_stage_ctrl
  import mw_stage_ctrl_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic [XLEN-1:0]       ex_alu_result,
  input  logic [XLEN-1:0]       ex_store_data,
  input  logic [XLEN-1:0]       ex_pc_plus4,
  input  logic [REG_ADDR_W-1:0] ex_write_address,
  input  logic                  ex_reg_write,
  input  logic [1:0]            ex_writeback_select,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic                  stall,
  mw_stage_ctrl_if.master       dmem,
  output logic [REG_ADDR_W-1:0] write_address_memory_write,
  output logic [1:0]            writeback_select_memory_write,
  output logic                  memory_write_enable,
  output logic                  instruction_valid,
  output logic                  mem_busy,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [XLEN-1:0]       wb_data
);

  logic                  slot_live;
  logic                  slot_reg_write;
  logic                  slot_mem_read;
  logic                  slot_mem_write;
  logic [XLEN-1:0]       slot_alu;
  logic [XLEN-1:0]       slot_store_data;
  logic [XLEN-1:0]       slot_pc4;
  logic [REG_ADDR_W-1:0] slot_waddr;
  logic [1:0]            slot_sel;

  logic capture_live;
  logic mem_start;

  assign capture_live = ex_valid & ~stall;
  assign mem_start    = ~mem_busy & capture_live & (ex_mem_read | ex_mem_write);

  // MW register: reload every un-held edge; bubbles carry zeroed fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_live       <= 1'b0;
      slot_reg_write  <= 1'b0;
      slot_mem_read   <= 1'b0;
      slot_mem_write  <= 1'b0;
      slot_alu        <= '0;
      slot_store_data <= '0;
      slot_pc4        <= '0;
      slot_waddr      <= '0;
      slot_sel        <= '0;
    end else if (!mem_busy) begin
      slot_live       <= capture_live;
      slot_reg_write  <= capture_live & ex_reg_write;
      slot_mem_read   <= capture_live & ex_mem_read;
      slot_mem_write  <= capture_live & ex_mem_write;
      slot_alu        <= capture_live ? ex_alu_result       : '0;
      slot_store_data <= capture_live ? ex_store_data       : '0;
      slot_pc4        <= capture_live ? ex_pc_plus4         : '0;
      slot_waddr      <= capture_live ? ex_write_address    : '0;
      slot_sel        <= capture_live ? ex_writeback_select : '0;
    end
  end

  dmem_access_fsm #(
    .XLEN(XLEN)
  ) u_fsm (
    .clk        (clk),
    .rst        (rst),
    .start      (mem_start),
    .slot_load  (slot_mem_read),
    .slot_store (slot_mem_write),
    .slot_addr  (slot_alu),
    .slot_wdata (slot_store_data),
    .dmem       (dmem),
    .mem_busy   (mem_busy)
  );

  assign instruction_valid             = ~slot_live;
  assign write_address_memory_write    = slot_waddr;
  assign writeback_select_memory_write = slot_sel;
  assign memory_write_enable           = slot_live & slot_reg_write & (slot_waddr != '0);

  assign wb_we   = memory_write_enable & ~mem_busy;
  assign wb_addr = slot_waddr;

  // Writeback source mux; load data is taken straight from the bus.
  always_comb begin
    wb_data = slot_alu;
    unique case (slot_sel)
      WB_PC4:  wb_data = slot_pc4;
      WB_MEM:  wb_data = dmem.rdata;
      default: wb_data = slot_alu;
    endcase
  end

endmodule

// File: tb/tb_mw_stage_ctrl.sv
// Self-checking bench for mw_stage_ctrl: vector table, directed multi-cycle
// sequences, and a randomized run against a transaction-level model.
module tb_mw_stage_ctrl;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [31:0] ex_pc_plus4;
  logic [4:0]  ex_write_address;
  logic        ex_reg_write;
  logic [1:0]  ex_writeback_select;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        stall;
  logic [4:0]  write_address_memory_write;
  logic [1:0]  writeback_select_memory_write;
  logic        memory_write_enable;
  logic        instruction_valid;
  logic        mem_busy;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  mw_stage_ctrl_if #(.XLEN(32)) dmem_bus ();

  mw_stage_ctrl #(
    .XLEN       (32),
    .REG_ADDR_W (5)
  ) dut (
    .clk                           (clk),
    .rst                           (rst),
    .ex_valid                      (ex_valid),
    .ex_alu_result                 (ex_alu_result),
    .ex_store_data                 (ex_store_data),
    .ex_pc_plus4                   (ex_pc_plus4),
    .ex_write_address              (ex_write_address),
    .ex_reg_write                  (ex_reg_write),
    .ex_writeback_select           (ex_writeback_select),
    .ex_mem_read                   (ex_mem_read),
    .ex_mem_write                  (ex_mem_write),
    .stall                         (stall),
    .dmem                          (dmem_bus),
    .write_address_memory_write    (write_address_memory_write),
    .writeback_select_memory_write (writeback_select_memory_write),
    .memory_write_enable           (memory_write_enable),
    .instruction_valid             (instruction_valid),
    .mem_busy                      (mem_busy),
    .wb_we                         (wb_we),
    .wb_addr                       (wb_addr),
    .wb_data                       (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic st, input logic [31:0] alu,
                       input logic [31:0] sd, input logic [31:0] pc4,
                       input logic [4:0] wa, input logic rw, input logic [1:0] sel,
                       input logic rd, input logic wr);
    ex_valid            = v;
    stall               = st;
    ex_alu_result       = alu;
    ex_store_data       = sd;
    ex_pc_plus4         = pc4;
    ex_write_address    = wa;
    ex_reg_write        = rw;
    ex_writeback_select = sel;
    ex_mem_read         = rd;
    ex_mem_write        = wr;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    dmem_bus.gnt    = 1'b0;
    dmem_bus.rvalid = 1'b0;
    dmem_bus.rdata  = '0;
    tick();
    tick();
    chk("rst_iv",    instruction_valid,   1);
    chk("rst_busy",  mem_busy,            0);
    chk("rst_req",   dmem_bus.req,        0);
    chk("rst_wbwe",  wb_we,               0);
    chk("rst_mwe",   memory_write_enable, 0);
    chk("rst_wbdat", wb_data,             0);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        v;
    logic        st;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [4:0]  wa;
    logic        rw;
    logic [1:0]  sel;
    logic        e_iv;
    logic        e_mwe;
    logic        e_we;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[8];

  // Transaction-level model state for the random run.
  logic        m_live, m_rw, m_rd, m_wr, m_granted;
  logic [31:0] m_alu, m_sd, m_pc4;
  logic [4:0]  m_wa;
  logic [1:0]  m_sel;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int busy_cnt;
    int we_cnt;

    tbl[0] = '{1, 0, 32'h1234,     32'h0,    5'd5,  1, 2'b00, 0, 1, 1, 32'h1234};
    tbl[1] = '{1, 0, 32'hAAAA,     32'h1000, 5'd31, 1, 2'b01, 0, 1, 1, 32'h1000};
    tbl[2] = '{1, 0, 32'h5A5A,     32'h44,   5'd12, 1, 2'b11, 0, 1, 1, 32'h5A5A};
    tbl[3] = '{1, 0, 32'h77,       32'h8,    5'd0,  1, 2'b00, 0, 0, 0, 32'h0};
    tbl[4] = '{1, 0, 32'h99,       32'h8,    5'd9,  0, 2'b00, 0, 0, 0, 32'h0};
    tbl[5] = '{1, 1, 32'h31,       32'h8,    5'd3,  1, 2'b00, 1, 0, 0, 32'h0};
    tbl[6] = '{0, 0, 32'h32,       32'h8,    5'd3,  1, 2'b00, 1, 0, 0, 32'h0};
    tbl[7] = '{1, 0, 32'hFFFFFFFF, 32'h8,    5'd1,  1, 2'b00, 0, 1, 1, 32'hFFFFFFFF};

    do_reset();

    // Single-cycle (non-memory) instructions from the vector table.
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].v, tbl[i].st, tbl[i].alu, 32'h0, tbl[i].pc4, tbl[i].wa,
            tbl[i].rw, tbl[i].sel, 0, 0);
      tick();
      chk($sformatf("vec%0d_iv", i),   instruction_valid,   tbl[i].e_iv);
      chk($sformatf("vec%0d_mwe", i),  memory_write_enable, tbl[i].e_mwe);
      chk($sformatf("vec%0d_wbwe", i), wb_we,               tbl[i].e_we);
      chk($sformatf("vec%0d_busy", i), mem_busy,            0);
      if (tbl[i].e_we) begin
        chk($sformatf("vec%0d_addr", i), wb_addr, tbl[i].wa);
        chk($sformatf("vec%0d_data", i), wb_data, tbl[i].e_data);
      end
    end

    // Load at 0x100: grant on the second request cycle, data after three
    // silent response cycles; stall held high throughout must be ignored.
    do_reset();
    drive(1, 0, 32'h100, 0, 32'h4, 5'd7, 1, 2'b10, 1, 0);
    tick();
    drive(1, 1, 32'h55, 0, 32'h8, 5'd9, 1, 2'b00, 0, 0);
    busy_cnt = 0;
    we_cnt   = 0;
    for (int i = 0; i < 6; i++) begin
      dmem_bus.gnt    = (i == 1);
      dmem_bus.rvalid = (i == 5);
      dmem_bus.rdata  = (i == 5) ? 32'hDEADBEEF : 32'h0BAD0BAD;
      #1;
      if (mem_busy) busy_cnt++;
      chk($sformatf("ld_iv%0d", i), instruction_valid,          0);
      chk($sformatf("ld_wa%0d", i), write_address_memory_write, 7);
      if (i == 0) begin
        chk("ld_req",  dmem_bus.req,  1);
        chk("ld_we",   dmem_bus.we,   0);
        chk("ld_addr", dmem_bus.addr, 32'h100);
      end
      if (i == 3) chk("ld_wait_req", dmem_bus.req, 0);
      if (wb_we) begin
        we_cnt++;
        chk("ld_wbdata", wb_data, 32'hDEADBEEF);
        chk("ld_wbaddr", wb_addr, 7);
      end
      tick();
    end
    dmem_bus.gnt    = 1'b0;
    dmem_bus.rvalid = 1'b0;
    chk("ld_busy_cycles", busy_cnt, 5);
    chk("ld_wb_pulses",   we_cnt,   1);
    #1;
    chk("stall_iv",  instruction_valid,   1);
    chk("stall_mwe", memory_write_enable, 0);

    // Store 0xCAFE to 0x40 with an immediate grant.
    do_reset();
    drive(1, 0, 32'h40, 32'hCAFE, 0, 5'd0, 0, 2'b00, 0, 1);
    tick();
    drive(1, 0, 32'h77, 0, 0, 5'd3, 1, 2'b00, 0, 0);
    dmem_bus.gnt = 1'b1;
    #1;
    chk("st_req",   dmem_bus.req,   1);
    chk("st_we",    dmem_bus.we,    1);
    chk("st_addr",  dmem_bus.addr,  32'h40);
    chk("st_wdata", dmem_bus.wdata, 32'hCAFE);
    chk("st_busy",  mem_busy,       0);
    chk("st_wbwe",  wb_we,          0);
    tick();
    dmem_bus.gnt = 1'b0;
    #1;
    chk("st_next_iv",   instruction_valid, 0);
    chk("st_next_wbwe", wb_we,             1);
    chk("st_next_addr", wb_addr,           3);
    chk("st_next_data", wb_data,           32'h77);

    // Reset asserted while waiting for load data.
    do_reset();
    drive(1, 0, 32'h200, 0, 0, 5'd4, 1, 2'b10, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    dmem_bus.gnt = 1'b1;
    tick();
    dmem_bus.gnt = 1'b0;
    #1;
    chk("rw_busy_before", mem_busy, 1);
    rst = 1'b1;
    #1;
    chk("rw_busy",  mem_busy,                   0);
    chk("rw_req",   dmem_bus.req,               0);
    chk("rw_wbwe",  wb_we,                      0);
    chk("rw_iv",    instruction_valid,          1);
    chk("rw_mwe",   memory_write_enable,        0);
    chk("rw_wa",    write_address_memory_write, 0);
    chk("rw_wbdat", wb_data,                    0);
    tick();
    rst             = 1'b0;
    dmem_bus.rvalid = 1'b1;
    dmem_bus.rdata  = 32'h12345678;
    #1;
    chk("rw_late_wbwe", wb_we,    0);
    chk("rw_late_busy", mem_busy, 0);
    tick();
    dmem_bus.rvalid = 1'b0;
    chk("rw_late_wbwe2", wb_we, 0);

    // Randomized traffic against the transaction-level model.
    do_reset();
    m_live = 0; m_rw = 0; m_rd = 0; m_wr = 0; m_granted = 0;
    m_alu = 0; m_sd = 0; m_pc4 = 0; m_wa = 0; m_sel = 0;
    for (int c = 0; c < 600; c++) begin
      logic        v, st, rd, wr, rw, pend, waiting, e_busy, e_req, e_mwe, e_wbwe;
      logic [1:0]  sel;
      logic [31:0] e_data;
      int unsigned op;
      v  = ($urandom % 5) != 0;
      st = ($urandom % 4) == 0;
      op = $urandom % 4;
      rd = (op == 0);
      wr = (op == 1);
      rw = wr ? 1'b0 : 1'($urandom % 2 == 0 ? 1 : ($urandom % 2));
      sel = rd ? 2'b10 : 2'($urandom % 4);
      drive(v, st, $urandom, $urandom, $urandom, 5'($urandom % 32), rw, sel, rd, wr);
      pend    = m_live && (m_rd || m_wr);
      waiting = pend && m_rd && m_granted;
      dmem_bus.gnt    = waiting ? 1'b0 : 1'($urandom % 2);
      dmem_bus.rvalid = waiting ? (($urandom % 3) == 0) : 1'b0;
      dmem_bus.rdata  = $urandom;
      #1;
      if (!pend)     e_busy = 1'b0;
      else if (m_wr) e_busy = !dmem_bus.gnt;
      else           e_busy = !m_granted || !dmem_bus.rvalid;
      e_req  = pend && !m_granted;
      e_mwe  = m_live && m_rw && (m_wa != 0);
      e_wbwe = e_mwe && !e_busy;
      e_data = (m_sel == 2'b01) ? m_pc4 : (m_sel == 2'b10) ? dmem_bus.rdata : m_alu;
      chk("rnd_busy", mem_busy,            e_busy);
      chk("rnd_iv",   instruction_valid,   !m_live);
      chk("rnd_mwe",  memory_write_enable, e_mwe);
      chk("rnd_wbwe", wb_we,               e_wbwe);
      chk("rnd_req",  dmem_bus.req,        e_req);
      if (m_live) begin
        chk("rnd_wa",  write_address_memory_write,    m_wa);
        chk("rnd_sel", writeback_select_memory_write, m_sel);
      end
      if (e_req) begin
        chk("rnd_dwe",   dmem_bus.we,    m_wr);
        chk("rnd_daddr", dmem_bus.addr,  m_alu);
        if (m_wr) chk("rnd_dwdata", dmem_bus.wdata, m_sd);
      end
      if (e_wbwe) begin
        chk("rnd_wbaddr", wb_addr, m_wa);
        chk("rnd_wbdata", wb_data, e_data);
      end
      if (!e_busy) begin
        m_live    = v && !st;
        m_rw      = m_live && rw;
        m_rd      = m_live && rd;
        m_wr      = m_live && wr;
        m_alu     = ex_alu_result;
        m_sd      = ex_store_data;
        m_pc4     = ex_pc_plus4;
        m_wa      = ex_write_address;
        m_sel     = sel;
        m_granted = 1'b0;
      end else if (e_req && dmem_bus.gnt) begin
        m_granted = 1'b1;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
